// File: rtl/irst_sched.sv
// irst_sched: host-configurable scheduler for the fetch-stage instruction-memory self-test.
// Starts runs on command or on a programmable period, holds the enable until the fetch
// stage reports done (or the run times out), then records run count, irq and err.
module irst_sched #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [15:0] cfg_rdata,
  input  logic        irst_done,
  output logic [15:0] irst_reg_data,
  output logic        busy,
  output logic        irq,
  output logic        err
);

  // tmo_cnt only ever holds 0..TIMEOUT-1
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRelease
  } state_e;

  state_e              state_q;
  logic                auto_en_q;
  logic [6:0]          pc_limit_q;
  logic [5:0]          mis_count_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_cnt_q;
  logic [TmoW-1:0]     tmo_cnt_q;
  logic [7:0]          run_cnt_q;
  logic                irq_q;
  logic                err_q;
  logic                en_q;
  logic                busy_q;
  logic [6:0]          snap_limit_q;
  logic [5:0]          snap_cnt_q;

  logic ctrl_wr;
  logic start_req;
  logic clear_req;
  logic period_on;
  logic auto_trig;

  // Decode host commands and the auto-trigger condition
  always_comb begin
    ctrl_wr   = cfg_we && (cfg_addr == 2'd0);
    start_req = ctrl_wr && cfg_wdata[1];
    clear_req = ctrl_wr && cfg_wdata[2];
    period_on = auto_en_q && (period_q != '0);
    auto_trig = period_on && (period_cnt_q == (period_q - PERIOD_W'(1)));
  end

  // Config registers, counters, sticky flags and the run FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      auto_en_q    <= 1'b0;
      pc_limit_q   <= '0;
      mis_count_q  <= '0;
      period_q     <= '0;
      period_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      run_cnt_q    <= '0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      snap_limit_q <= '0;
      snap_cnt_q   <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: auto_en_q <= cfg_wdata[0];
          2'd1: begin
            pc_limit_q  <= cfg_wdata[14:8];
            mis_count_q <= cfg_wdata[5:0];
          end
          2'd2: period_q <= PERIOD_W'(cfg_wdata);
          default: ;
        endcase
      end

      // Clear first; a set later in this block overrides it (set wins)
      if (clear_req) begin
        irq_q <= 1'b0;
        err_q <= 1'b0;
      end

      if (ctrl_wr && !cfg_wdata[0]) begin
        period_cnt_q <= '0;
      end else if ((state_q == StIdle) && period_on) begin
        period_cnt_q <= period_cnt_q + PERIOD_W'(1);
      end

      case (state_q)
        StIdle: begin
          if (start_req || auto_trig) begin
            state_q      <= StRun;
            en_q         <= 1'b1;
            busy_q       <= 1'b1;
            period_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            snap_limit_q <= pc_limit_q;
            snap_cnt_q   <= mis_count_q;
          end
        end
        StRun: begin
          if (irst_done) begin
            state_q   <= StRelease;
            en_q      <= 1'b0;
            run_cnt_q <= run_cnt_q + 8'd1;
            irq_q     <= 1'b1;
          end else if (tmo_cnt_q == TmoLast) begin
            state_q <= StRelease;
            en_q    <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StRelease: begin
          // Wait for the fetch stage to leave its done state before allowing another run
          if (!irst_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Host read mux; start/clear bits always read back as 0
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata = {15'd0, auto_en_q};
      2'd1: cfg_rdata = {1'b0, pc_limit_q, 2'b00, mis_count_q};
      2'd2: cfg_rdata = 16'(period_q);
      default: cfg_rdata = {run_cnt_q, 5'd0, irq_q, err_q, busy_q};
    endcase
  end

  assign irst_reg_data = {en_q, snap_limit_q, 2'b00, snap_cnt_q};
  assign busy          = busy_q;
  assign irq           = irq_q;
  assign err           = err_q;

endmodule

// File: tb/tb_irst_sched.sv
// Directed bench for irst_sched: one instance with the default timeout and one with
// TIMEOUT=16 for the abort path. Expected values are hand-computed constants.
module tb_irst_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_a, we_b;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata_a, rdata_b;
  logic        done_a, done_b;
  logic [15:0] reg_a, reg_b;
  logic        busy_a, busy_b, irq_a, irq_b, err_a, err_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irst_sched dut_a (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (we_a),
    .cfg_addr      (addr),
    .cfg_wdata     (wdata),
    .cfg_rdata     (rdata_a),
    .irst_done     (done_a),
    .irst_reg_data (reg_a),
    .busy          (busy_a),
    .irq           (irq_a),
    .err           (err_a)
  );

  irst_sched #(.TIMEOUT(16)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (we_b),
    .cfg_addr      (addr),
    .cfg_wdata     (wdata),
    .cfg_rdata     (rdata_b),
    .irst_done     (done_b),
    .irst_reg_data (reg_b),
    .busy          (busy_b),
    .irq           (irq_b),
    .err           (err_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel_b, input logic [1:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    if (sel_b) we_b = 1'b1;
    else       we_a = 1'b1;
    tick();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic rd(input bit sel_b, input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = sel_b ? rdata_b : rdata_a;
  endtask

  task automatic chk_reg(input string tag, input bit sel_b, input logic [1:0] a,
                         input logic [15:0] exp);
    logic [15:0] d;
    rd(sel_b, a, d);
    chk(tag, d, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int starts[3];
    int nstart;
    int age;
    int en_cnt;

    rst = 1'b1; we_a = 1'b0; we_b = 1'b0; addr = 2'd0; wdata = '0;
    done_a = 1'b0; done_b = 1'b0;
    do_reset();

    // Reset state
    chk("rst_reg", reg_a, 16'h0000);
    chk("rst_busy", {15'd0, busy_a}, 16'd0);
    chk("rst_irq", {15'd0, irq_a}, 16'd0);
    chk("rst_err", {15'd0, err_a}, 16'd0);
    chk_reg("rst_status", 1'b0, 2'd3, 16'h0000);

    // Basic commanded run
    wr(1'b0, 2'd1, 16'h3A15);
    chk_reg("test_rd", 1'b0, 2'd1, 16'h3A15);
    wr(1'b0, 2'd0, 16'h0002);
    chk("start_reg", reg_a, 16'hBA15);
    chk("start_busy", {15'd0, busy_a}, 16'd1);
    repeat (20) tick();
    chk("run_hold_en", reg_a, 16'hBA15);
    done_a = 1'b1;
    tick();
    chk("done_reg", reg_a, 16'h3A15);
    chk_reg("done_status", 1'b0, 2'd3, 16'h0105);
    tick();
    chk("release_hold_busy", {15'd0, busy_a}, 16'd1);
    done_a = 1'b0;
    tick();
    chk_reg("idle_status", 1'b0, 2'd3, 16'h0104);
    wr(1'b0, 2'd1, 16'hFFFF);
    chk_reg("test_mask", 1'b0, 2'd1, 16'h7F3F);
    chk("idle_snapshot", reg_a, 16'h3A15);
    wr(1'b0, 2'd0, 16'h0004);
    chk_reg("clear_status", 1'b0, 2'd3, 16'h0100);
    chk_reg("ctrl_rd", 1'b0, 2'd0, 16'h0000);

    // Timeout on the TIMEOUT=16 instance
    wr(1'b1, 2'd0, 16'h0002);
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (reg_b[15]) en_cnt++;
      tick();
    end
    chk("tmo_en_cycles", 16'(en_cnt), 16'd16);
    chk_reg("tmo_status", 1'b1, 2'd3, 16'h0002);
    wr(1'b1, 2'd0, 16'h0004);
    chk("tmo_err_clr", {15'd0, err_b}, 16'd0);

    // Periodic auto trigger with a fetch-stage model answering after 5 cycles
    do_reset();
    wr(1'b0, 2'd2, 16'd100);
    chk_reg("period_rd", 1'b0, 2'd2, 16'h0064);
    wr(1'b0, 2'd0, 16'h0001);
    chk_reg("ctrl_auto_rd", 1'b0, 2'd0, 16'h0001);
    nstart = 0;
    age = 0;
    for (int c = 1; c <= 330; c++) begin
      tick();
      if (reg_a[15]) begin
        if (age == 0) begin
          if (nstart < 3) starts[nstart] = c;
          nstart++;
        end
        age++;
        if (age == 5) done_a = 1'b1;
      end else begin
        age = 0;
        done_a = 1'b0;
      end
    end
    chk("auto_nstart", 16'(nstart), 16'd3);
    chk("auto_start0", 16'(starts[0]), 16'd100);
    chk("auto_start1", 16'(starts[1]), 16'd206);
    chk("auto_start2", 16'(starts[2]), 16'd312);
    wr(1'b0, 2'd0, 16'h0000);
    chk_reg("auto_status", 1'b0, 2'd3, 16'h0304);

    // Start and TEST write while busy are ignored for this run
    wr(1'b0, 2'd1, 16'h3A15);
    wr(1'b0, 2'd0, 16'h0002);
    chk("busy_start_reg", reg_a, 16'hBA15);
    repeat (3) tick();
    wr(1'b0, 2'd0, 16'h0002);
    wr(1'b0, 2'd1, 16'h7F3F);
    chk("midrun_reg", reg_a, 16'hBA15);
    done_a = 1'b1;
    tick();
    chk("midrun_done_reg", reg_a, 16'h3A15);
    done_a = 1'b0;
    tick();
    chk("midrun_idle_reg", reg_a, 16'h3A15);
    repeat (5) tick();
    chk_reg("no_second_run", 1'b0, 2'd3, 16'h0404);
    wr(1'b0, 2'd0, 16'h0002);
    chk("next_run_reg", reg_a, 16'hFF3F);

    // Reset in RUN
    rst = 1'b1;
    tick();
    chk("rstrun_reg", reg_a, 16'h0000);
    chk("rstrun_busy", {15'd0, busy_a}, 16'd0);
    chk_reg("rstrun_status", 1'b0, 2'd3, 16'h0000);
    rst = 1'b0;
    tick();

    // run_cnt wrap, and set-wins against a simultaneous clear
    for (int r = 0; r < 255; r++) begin
      wr(1'b0, 2'd0, 16'h0002);
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      tick();
    end
    chk_reg("cnt_255", 1'b0, 2'd3, 16'hFF04);
    wr(1'b0, 2'd0, 16'h0002);
    addr = 2'd0; wdata = 16'h0004; we_a = 1'b1; done_a = 1'b1;
    tick();
    we_a = 1'b0;
    chk_reg("wrap_setwins", 1'b0, 2'd3, 16'h0005);
    done_a = 1'b0;
    tick();
    chk_reg("wrap_idle", 1'b0, 2'd3, 16'h0004);

    // Start and clear together in IDLE
    wr(1'b0, 2'd0, 16'h0006);
    chk("stclr_irq", {15'd0, irq_a}, 16'd0);
    chk("stclr_busy", {15'd0, busy_a}, 16'd1);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    chk_reg("stclr_status", 1'b0, 2'd3, 16'h0104);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
